// File: rtl/systolic_skew_feeder_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_pkg
// Purpose  : Shared types and default sizes for the systolic skew feeder.
//            feeder_state_t encodes the tile sequencer states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  localparam int DEFAULT_ARRAY_SIZE = 128;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LEN_W      = 16;

endpackage

`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
//------------------------------------------------------------------------------
// Module   : systolic_skew_feeder_if
// Purpose  : Bundles the tile-control, row-vector handshake and array-side
//            outputs of the skew feeder.
//            master : upstream producer (drives start/tile_len/in_valid/in_data)
//            slave  : the feeder (drives in_ready and all array-side outputs)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_W      = DEFAULT_LEN_W
) ();

  logic                             start;
  logic [LEN_W-1:0]                 tile_len;
  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data;
  logic [ARRAY_SIZE-1:0]            out_lane_valid;
  logic                             mac_enable;
  logic                             accum_clear;
  logic                             busy;
  logic                             done;

  modport master (
    output start, tile_len, in_valid, in_data,
    input  in_ready, out_data, out_lane_valid, mac_enable, accum_clear, busy, done
  );

  modport slave (
    input  start, tile_len, in_valid, in_data,
    output in_ready, out_data, out_lane_valid, mac_enable, accum_clear, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
//------------------------------------------------------------------------------
// Module   : skew_delay_line
// Purpose  : DEPTH-stage shift register with shift enable; one per lane.
// Ports    : clk, reset (async, active-high), en (shift), d (in), q (last stage)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (en) begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : systolic_skew_feeder
// Purpose  : Feeds one tile of row vectors into the left edge of a systolic
//            array, delaying lane k by k cycles so wavefronts arrive aligned,
//            and drives the array's accum_clear / mac_enable controls.
// Ports    : clk, reset (async, active-high)
//            bus.start/tile_len        tile request, sampled in IDLE only
//            bus.in_valid/in_ready     row-vector handshake, in_data lanes
//            bus.out_data/lane_valid   skewed lanes to the array (registered)
//            bus.mac_enable            high while out_data carries tile content
//            bus.accum_clear           1-cycle pulse before streaming
//            bus.busy / bus.done       state != IDLE / completion pulse
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_W      = DEFAULT_LEN_W
) (
  input  logic clk,
  input  logic reset,
  systolic_skew_feeder_if.slave bus
);

  localparam int c_drain_w = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(ARRAY_SIZE - 1);

  feeder_state_t r_state;
  feeder_state_t w_state_nxt;

  logic [LEN_W-1:0]                 r_len;
  logic [LEN_W-1:0]                 r_beat;
  logic [c_drain_w-1:0]             r_drain;
  logic                             r_in_valid;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] r_in_data;
  logic                             r_adv;
  logic                             r_mac;
  logic                             r_clear;
  logic                             r_done;

  logic                             w_in_ready;
  logic                             w_hs;
  logic                             w_start_ok;
  logic                             w_last_beat;
  logic                             w_drain_last;
  logic                             w_shift;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_out_data;
  logic [ARRAY_SIZE-1:0]            w_out_valid;

  assign w_in_ready   = (r_state == STREAM);
  assign w_hs         = bus.in_valid & w_in_ready;
  assign w_start_ok   = bus.start & (bus.tile_len != '0);
  // r_beat counts accepted beats before this one, so it never reaches
  // tile_len until the final beat: a full-range tile_len cannot wrap.
  assign w_last_beat  = (r_beat == r_len - 1'b1);
  assign w_drain_last = (r_drain == c_drain_last);
  assign w_shift      = (r_state == STREAM) || (r_state == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = STREAM;
      STREAM:  if (w_hs && w_last_beat) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len   <= '0;
      r_beat  <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == IDLE && w_start_ok) begin
        r_len  <= bus.tile_len;
        r_beat <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + 1'b1;
      end
      if (r_state == STREAM)     r_drain <= '0;
      else if (r_state == DRAIN) r_drain <= r_drain + 1'b1;
    end
  end

  // The accepted vector (or a zero bubble) is captured every cycle; the skew
  // lines then advance one cycle behind the state so that this entry register
  // plus k+1 line stages gives lane k its 1+k cycle latency, and the last
  // DRAIN zeros still flush through the deepest lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_valid <= 1'b0;
      r_in_data  <= '0;
      r_adv      <= 1'b0;
      r_mac      <= 1'b0;
      r_clear    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_valid <= w_hs;
      r_in_data  <= w_hs ? bus.in_data : '0;
      r_adv      <= w_shift;
      r_mac      <= r_adv;
      r_clear    <= (r_state == CLEAR);
      r_done     <= (r_state == DRAIN) && w_drain_last;
    end
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    logic [DATA_WIDTH:0] w_q;

    skew_delay_line #(
      .DEPTH(k + 1),
      .WIDTH(DATA_WIDTH + 1)
    ) u_dly (
      .clk   (clk),
      .reset (reset),
      .en    (r_adv),
      .d     ({r_in_valid, r_in_data[k*DATA_WIDTH +: DATA_WIDTH]}),
      .q     (w_q)
    );

    assign w_out_data[k*DATA_WIDTH +: DATA_WIDTH] = w_q[DATA_WIDTH-1:0];
    assign w_out_valid[k]                         = w_q[DATA_WIDTH];
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_data       = w_out_data;
  assign bus.out_lane_valid = w_out_valid;
  assign bus.mac_enable     = r_mac;
  assign bus.accum_clear    = r_clear;
  assign bus.busy           = (r_state != IDLE);
  assign bus.done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_systolic_skew_feeder
// Purpose  : Self-checking bench for systolic_skew_feeder (4 lanes x 8 bits).
//            Accepted beats are queued per lane with their acceptance edge and
//            compared when lane k should show them, 1+k edges later.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 4;

  typedef struct {
    int             t;
    logic [DW-1:0]  d;
  } item_t;

  logic clk = 1'b0;
  logic reset;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  item_t lane_q [N][$];

  systolic_skew_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every lane every cycle is either the due beat or a zero bubble.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic [DW-1:0] od;
      logic          ov;
      od = bus.out_data[k*DW +: DW];
      ov = bus.out_lane_valid[k];
      while (lane_q[k].size() > 0 && lane_q[k][0].t + 1 + k < cyc) begin
        checks++; failures++;
        $display("FAIL sb_missing lane%0d: beat from edge %0d not seen, now %0d", k, lane_q[k][0].t, cyc);
        lane_q[k].delete(0);
      end
      checks++;
      if (lane_q[k].size() > 0 && lane_q[k][0].t + 1 + k == cyc) begin
        if (ov !== 1'b1 || od !== lane_q[k][0].d) begin
          failures++;
          $display("FAIL sb_lane%0d cyc=%0d: got v=%0b d=%0h expected v=1 d=%0h", k, cyc, ov, od, lane_q[k][0].d);
        end
        lane_q[k].delete(0);
      end else if (ov !== 1'b0 || od !== '0) begin
        failures++;
        $display("FAIL sb_bubble lane%0d cyc=%0d: got v=%0b d=%0h expected v=0 d=0", k, cyc, ov, od);
      end
    end
  end

  task automatic assert_reset_mid_cycle();
    #2;
    reset = 1'b1;
    for (int k = 0; k < N; k++) lane_q[k].delete();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic watch_done(input int n, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cnt++;
        at = cyc;
      end
    end
  endtask

  // Drives one tile. Returns at the negedge after the last accepted beat
  // (cyc == t_last). Records observed accum_clear pulses for the caller.
  task automatic run_tile(input int len, input bit use_pat, input logic [31:0] vpat,
                          input int gap_pct, input bit rand_data, input bit poke_start,
                          output int t_first, output int t_last, output int clear_cnt,
                          output int clear_cyc, output int n_beats);
    int            pi;
    int            it;
    int            beats;
    logic          v;
    logic [N*DW-1:0] d;
    item_t         e;
    pi = 0; it = 0; beats = 0;
    t_first = -1; t_last = -1; clear_cnt = 0; clear_cyc = -1;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.tile_len = LW'(len);
    bus.in_valid = 1'b0;
    while (beats < len && it < 200) begin
      @(negedge clk);
      it++;
      if (bus.accum_clear === 1'b1) begin
        clear_cnt++;
        clear_cyc = cyc;
      end
      if (poke_start && bus.in_ready === 1'b1) begin
        bus.start    = 1'b1;
        bus.tile_len = LW'(len + 3);
      end else begin
        bus.start = 1'b0;
      end
      if (use_pat) begin
        v = 1'b0;
        if (bus.in_ready === 1'b1) begin
          v = vpat[pi];
          pi++;
        end
      end else begin
        v = ($urandom_range(0, 99) >= gap_pct);
      end
      for (int k = 0; k < N; k++)
        d[k*DW +: DW] = rand_data ? DW'($urandom) : DW'(N*beats + k + 1);
      bus.in_valid = v;
      bus.in_data  = d;
      if (v && bus.in_ready === 1'b1) begin
        for (int k = 0; k < N; k++) begin
          e.t = cyc + 1;
          e.d = d[k*DW +: DW];
          lane_q[k].push_back(e);
        end
        if (beats == 0) t_first = cyc + 1;
        t_last = cyc + 1;
        beats++;
      end
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    n_beats = beats;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%0b in_ready=%0b done=%0b expected all 0", bus.busy, bus.in_ready, bus.done);
    end
    checks++;
    if (bus.mac_enable !== 1'b0 || bus.accum_clear !== 1'b0 || bus.out_data !== '0 || bus.out_lane_valid !== '0) begin
      failures++;
      $display("FAIL reset_out: got mac=%0b clr=%0b data=%0h valid=%0b expected all 0",
               bus.mac_enable, bus.accum_clear, bus.out_data, bus.out_lane_valid);
    end
    release_reset();
    // Get into STREAM with bubbles, then reset mid-cycle.
    bus.start = 1'b1; bus.tile_len = LW'(3);
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.mac_enable !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stream: got busy=%0b in_ready=%0b mac=%0b expected 1 1 1", bus.busy, bus.in_ready, bus.mac_enable);
    end
    assert_reset_mid_cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.mac_enable !== 1'b0 || bus.accum_clear !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset_ctrl: got busy=%0b rdy=%0b mac=%0b clr=%0b done=%0b expected all 0",
               bus.busy, bus.in_ready, bus.mac_enable, bus.accum_clear, bus.done);
    end
    checks++;
    if (bus.out_data !== '0 || bus.out_lane_valid !== '0) begin
      failures++;
      $display("FAIL midrun_reset_out: got data=%0h valid=%0b expected 0 0", bus.out_data, bus.out_lane_valid);
    end
    release_reset();
  endtask

  task automatic test_back_to_back();
    int tf, tl, cc, cy, nb, dcnt, dat;
    run_tile(2, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, tf, tl, cc, cy, nb);
    checks++;
    if (nb !== 2 || tl !== tf + 1) begin
      failures++;
      $display("FAIL b2b_accept: got beats=%0d span=%0d expected beats=2 span=1", nb, tl - tf);
    end
    checks++;
    if (cc !== 1 || cy !== tf - 1) begin
      failures++;
      $display("FAIL b2b_accum_clear: got pulses=%0d at=%0d expected 1 at %0d", cc, cy, tf - 1);
    end
    checks++;
    if (bus.out_data[0 +: DW] !== 8'd1) begin
      failures++;
      $display("FAIL b2b_lane0_first: got %0d expected 1", bus.out_data[0 +: DW]);
    end
    dcnt = 0; dat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin dcnt++; dat = cyc; end
      if (i == 1) begin
        checks++;
        if (bus.out_data[0 +: DW] !== 8'd5) begin
          failures++;
          $display("FAIL b2b_lane0_second: got %0d expected 5", bus.out_data[0 +: DW]);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (bus.out_data[3*DW +: DW] !== ((i == 3) ? 8'd4 : 8'd8)) begin
          failures++;
          $display("FAIL b2b_lane3_i%0d: got %0d expected %0d", i, bus.out_data[3*DW +: DW], (i == 3) ? 4 : 8);
        end
      end
      if (i == 4 || i == 7) begin
        checks++;
        if (bus.mac_enable !== ((i == 4) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL b2b_mac_i%0d: got %0b expected %0b", i, bus.mac_enable, (i == 4) ? 1 : 0);
        end
      end
    end
    checks++;
    if (dcnt !== 1 || dat !== tl + 4) begin
      failures++;
      $display("FAIL b2b_done: got pulses=%0d at=%0d expected 1 at %0d", dcnt, dat, tl + 4);
    end
  endtask

  task automatic test_gaps();
    int tf, tl, cc, cy, nb, dcnt, dat, mac_low;
    run_tile(3, 1'b1, 32'h0000_0019, 0, 1'b0, 1'b0, tf, tl, cc, cy, nb);
    checks++;
    if (nb !== 3 || tl !== tf + 4) begin
      failures++;
      $display("FAIL gap_accept: got beats=%0d span=%0d expected beats=3 span=4", nb, tl - tf);
    end
    checks++;
    if (bus.out_lane_valid[3] !== 1'b1 || bus.out_data[3*DW +: DW] !== 8'd4) begin
      failures++;
      $display("FAIL gap_lane3_beat1: got v=%0b d=%0d expected v=1 d=4", bus.out_lane_valid[3], bus.out_data[3*DW +: DW]);
    end
    mac_low = 0;
    if (bus.mac_enable !== 1'b1) mac_low++;
    dcnt = 0; dat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin dcnt++; dat = cyc; end
      if (i <= 5 && bus.mac_enable !== 1'b1) mac_low++;
      if (i == 1 || i == 2) begin
        checks++;
        if (bus.out_lane_valid[3] !== 1'b0 || bus.out_data[3*DW +: DW] !== 8'd0) begin
          failures++;
          $display("FAIL gap_lane3_bubble_i%0d: got v=%0b d=%0d expected v=0 d=0", i, bus.out_lane_valid[3], bus.out_data[3*DW +: DW]);
        end
      end
    end
    checks++;
    if (mac_low !== 0) begin
      failures++;
      $display("FAIL gap_mac_enable: got %0d low cycles expected 0", mac_low);
    end
    checks++;
    if (dcnt !== 1 || dat !== tl + 4) begin
      failures++;
      $display("FAIL gap_done: got pulses=%0d at=%0d expected 1 at %0d", dcnt, dat, tl + 4);
    end
  endtask

  task automatic test_ignored_start();
    int tf, tl, cc, cy, nb, dcnt, dat, bad;
    run_tile(2, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, tf, tl, cc, cy, nb);
    checks++;
    if (nb !== 2 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_ignored: got beats=%0d in_ready=%0b busy=%0b expected 2 0 1", nb, bus.in_ready, bus.busy);
    end
    watch_done(10, dcnt, dat);
    checks++;
    if (dcnt !== 1 || dat !== tl + 4) begin
      failures++;
      $display("FAIL busy_start_done: got pulses=%0d at=%0d expected 1 at %0d", dcnt, dat, tl + 4);
    end
    bus.start = 1'b1; bus.tile_len = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = (i < 2);
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.accum_clear !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL zero_len_start: got %0d cycles not idle expected 0", bad);
    end
  endtask

  task automatic test_reset_in_drain();
    int tf, tl, cc, cy, nb, dcnt, dat;
    run_tile(1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, tf, tl, cc, cy, nb);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL drain_state: got busy=%0b in_ready=%0b expected 1 0", bus.busy, bus.in_ready);
    end
    assert_reset_mid_cycle();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL drain_reset: got busy=%0b done=%0b expected 0 0", bus.busy, bus.done);
    end
    release_reset();
    watch_done(8, dcnt, dat);
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL drain_reset_no_done: got %0d pulses expected 0", dcnt);
    end
    run_tile(1, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, tf, tl, cc, cy, nb);
    watch_done(10, dcnt, dat);
    checks++;
    if (nb !== 1 || cc !== 1 || dcnt !== 1 || dat !== tl + 4) begin
      failures++;
      $display("FAIL after_reset_tile: got beats=%0d clr=%0d done=%0d at %0d expected 1 1 1 at %0d", nb, cc, dcnt, dat, tl + 4);
    end
  endtask

  task automatic test_max_len();
    int tf, tl, cc, cy, nb, dcnt, dat;
    run_tile(15, 1'b0, 32'h0, 30, 1'b1, 1'b0, tf, tl, cc, cy, nb);
    checks++;
    if (nb !== 15 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL max_len_accept: got beats=%0d in_ready=%0b expected 15 0", nb, bus.in_ready);
    end
    watch_done(10, dcnt, dat);
    checks++;
    if (dcnt !== 1 || dat !== tl + 4) begin
      failures++;
      $display("FAIL max_len_done: got pulses=%0d at=%0d expected 1 at %0d", dcnt, dat, tl + 4);
    end
  endtask

  task automatic test_random_tiles();
    int tf, tl, cc, cy, nb, dcnt, dat, len;
    for (int n = 0; n < 100; n++) begin
      len = $urandom_range(1, 6);
      run_tile(len, 1'b0, 32'h0, 40, 1'b1, 1'b0, tf, tl, cc, cy, nb);
      watch_done(8, dcnt, dat);
      checks++;
      if (nb !== len || cc !== 1 || dcnt !== 1 || dat !== tl + 4 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_tile%0d: got beats=%0d clr=%0d done=%0d at %0d busy=%0b expected %0d 1 1 at %0d 0",
                 n, nb, cc, dcnt, dat, bus.busy, len, tl + 4);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.tile_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_ignored_start();
    test_reset_in_drain();
    test_max_len();
    test_random_tiles();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
